ipsmacge_txframing: RTL and testbench

Transmit framer for the triple-speed MAC. It pulls frame bytes from the TX FIFO and builds the frame on the 8-bit PHY-side byte stream: preamble, SFD, payload, optional pad to minimum length, appended FCS, and inter-packet gap. It sits between the TX FIFO clock converter and the GMII/MII/RGMII TX adaptor, and advances only on byte-enable ticks so the same logic serves 10, 100 and 1000 Mbps.

---
 rtl/ipsmacge_txframing.sv | 195 +++++++++++++++++++
 tb/tb_ipsmacge_txframing.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ipsmacge_txframing.sv
// Transmit framer: preamble, SFD, payload, optional pad, FCS and IPG onto the
// PHY-side byte stream, advancing only on byte-enable ticks.
module ipsmacge_txframing #(
    parameter int unsigned          DAT_DW  = 8,
    parameter int unsigned          CNT_W   = 11,
    parameter logic [DAT_DW-1:0]    DAT_PRM = 8'h55,
    parameter logic [DAT_DW-1:0]    DAT_SFD = 8'hD5,
    parameter int unsigned          MIN_PAY = 60
) (
    input  logic              txclk,
    input  logic              rst_,
    input  logic              itick,
    input  logic [DAT_DW-1:0] idat,
    input  logic              isop,
    input  logic              ieop,
    input  logic              ival,
    output logic              ordy,
    output logic [DAT_DW-1:0] ogdat,
    output logic              ogdv,
    output logic              oger,
    output logic              osent,
    output logic              ounder,
    input  logic              up_txen,
    input  logic [3:0]        up_txnumprm,
    input  logic              up_txpad,
    input  logic [3:0]        up_txipg
);

    localparam logic [CNT_W:0] MIN_PAY_W = (CNT_W+1)'(MIN_PAY);

    typedef enum logic [2:0] {
        S_IDLE, S_PRM, S_SFD, S_PAY, S_PAD, S_FCS, S_IPG, S_DRAIN
    } state_t;

    state_t             r_state, w_nstate;
    logic [3:0]         r_prm_cnt, w_prm_cnt;
    logic [CNT_W-1:0]   r_cnt, w_cnt;
    logic [1:0]         r_fcs_cnt, w_fcs_cnt;
    logic [3:0]         r_ipg_cnt, w_ipg_cnt;
    logic [31:0]        r_crc, w_crc;
    logic [DAT_DW-1:0]  r_ogdat, w_dat;
    logic               r_ogdv, w_dv;
    logic               r_oger, w_er;
    logic               r_osent, w_sent;
    logic               r_ounder, w_under;
    logic               w_pull;
    logic [CNT_W-1:0]   w_cnt_sat;
    logic [CNT_W:0]     w_cnt_inc;
    logic [4:0]         w_ipg_len;

    // Reflected Ethernet CRC-32, one byte per call
    function automatic logic [31:0] crc32_8b(input logic [31:0] ci, input logic [7:0] di);
        logic [31:0] c;
        c = ci ^ {24'h0, di};
        for (int b = 0; b < 8; b++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    assign w_cnt_sat = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
    assign w_cnt_inc = {1'b0, r_cnt} + (CNT_W+1)'(1);
    assign w_ipg_len = (up_txipg == 4'd0) ? 5'd1 : {1'b0, up_txipg};

    always_ff @(posedge txclk) begin
        if (!rst_) begin
            r_state   <= S_IDLE;
            r_prm_cnt <= '0;
            r_cnt     <= '0;
            r_fcs_cnt <= '0;
            r_ipg_cnt <= '0;
            r_crc     <= '1;
            r_ogdat   <= '0;
            r_ogdv    <= 1'b0;
            r_oger    <= 1'b0;
            r_osent   <= 1'b0;
            r_ounder  <= 1'b0;
        end else if (itick) begin
            r_state   <= w_nstate;
            r_prm_cnt <= w_prm_cnt;
            r_cnt     <= w_cnt;
            r_fcs_cnt <= w_fcs_cnt;
            r_ipg_cnt <= w_ipg_cnt;
            r_crc     <= w_crc;
            r_ogdat   <= w_dat;
            r_ogdv    <= w_dv;
            r_oger    <= w_er;
            r_osent   <= w_sent;
            r_ounder  <= w_under;
        end
    end

    // Next state, datapath updates and per-tick output values
    always_comb begin
        w_nstate  = r_state;
        w_prm_cnt = r_prm_cnt;
        w_cnt     = r_cnt;
        w_fcs_cnt = r_fcs_cnt;
        w_ipg_cnt = r_ipg_cnt;
        w_crc     = r_crc;
        w_dat     = '0;
        w_dv      = 1'b0;
        w_er      = 1'b0;
        w_sent    = 1'b0;
        w_under   = 1'b0;
        w_pull    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_prm_cnt = '0;
                if (ival && !isop) begin
                    w_pull = 1'b1;
                end else if (up_txen && ival && isop) begin
                    w_nstate = S_PRM;
                end
            end
            S_PRM: begin
                w_dv  = 1'b1;
                w_dat = DAT_PRM;
                if (r_prm_cnt == up_txnumprm) begin
                    w_nstate = S_SFD;
                end else begin
                    w_prm_cnt = r_prm_cnt + 4'd1;
                end
            end
            S_SFD: begin
                w_dv     = 1'b1;
                w_dat    = DAT_SFD;
                w_crc    = '1;
                w_cnt    = '0;
                w_nstate = S_PAY;
            end
            S_PAY: begin
                w_pull = 1'b1;
                w_dv   = 1'b1;
                if (ival) begin
                    w_dat = idat;
                    w_crc = crc32_8b(r_crc, 8'(idat));
                    w_cnt = w_cnt_sat;
                    if (ieop) begin
                        w_fcs_cnt = '0;
                        w_nstate  = (up_txpad && (w_cnt_inc < MIN_PAY_W)) ? S_PAD : S_FCS;
                    end
                end else begin
                    w_er     = 1'b1;
                    w_under  = 1'b1;
                    w_nstate = S_DRAIN;
                end
            end
            S_PAD: begin
                w_dv  = 1'b1;
                w_crc = crc32_8b(r_crc, 8'h00);
                w_cnt = w_cnt_sat;
                if (w_cnt_inc >= MIN_PAY_W) begin
                    w_fcs_cnt = '0;
                    w_nstate  = S_FCS;
                end
            end
            S_FCS: begin
                w_dv  = 1'b1;
                w_dat = DAT_DW'(~r_crc[7:0]);
                w_crc = {8'h00, r_crc[31:8]};
                if (r_fcs_cnt == 2'd3) begin
                    w_sent    = 1'b1;
                    w_ipg_cnt = '0;
                    w_nstate  = S_IPG;
                end else begin
                    w_fcs_cnt = r_fcs_cnt + 2'd1;
                end
            end
            S_IPG: begin
                if (({1'b0, r_ipg_cnt} + 5'd1) >= w_ipg_len) begin
                    w_nstate = S_IDLE;
                end else begin
                    w_ipg_cnt = r_ipg_cnt + 4'd1;
                end
            end
            S_DRAIN: begin
                w_pull = 1'b1;
                if (ival && ieop) begin
                    w_ipg_cnt = '0;
                    w_nstate  = S_IPG;
                end
            end
            default: w_nstate = S_IDLE;
        endcase
    end

    assign ordy   = rst_ & itick & w_pull;
    assign ogdat  = r_ogdat;
    assign ogdv   = r_ogdv;
    assign oger   = r_oger;
    assign osent  = r_osent;
    assign ounder = r_ounder;

endmodule

// File: tb/tb_ipsmacge_txframing.sv
// Directed bench for ipsmacge_txframing: vector table of frame scenarios plus
// hand-written reset, idle-drop and enable sequences.
module tb_ipsmacge_txframing;

    logic       txclk = 1'b0;
    logic       rst_;
    logic       itick;
    logic [7:0] idat;
    logic       isop, ieop, ival;
    logic       ordy;
    logic [7:0] ogdat;
    logic       ogdv, oger, osent, ounder;
    logic       up_txen;
    logic [3:0] up_txnumprm;
    logic       up_txpad;
    logic [3:0] up_txipg;

    always #5 txclk = ~txclk;

    ipsmacge_txframing dut (
        .txclk(txclk), .rst_(rst_), .itick(itick), .idat(idat), .isop(isop),
        .ieop(ieop), .ival(ival), .ordy(ordy), .ogdat(ogdat), .ogdv(ogdv),
        .oger(oger), .osent(osent), .ounder(ounder), .up_txen(up_txen),
        .up_txnumprm(up_txnumprm), .up_txpad(up_txpad), .up_txipg(up_txipg)
    );

    typedef struct {
        logic [7:0] d;
        logic       sop;
        logic       eop;
    } fb_t;

    typedef struct {
        logic [7:0] d;
        logic       dv;
        logic       er;
        logic       sent;
        logic       under;
    } smp_t;

    typedef struct {
        int len; int pad; int tper; int und; int prm; int ipg;
        int seg0; int seg1; int gap; int sent; int under;
    } vec_t;

    fb_t  fq[$];
    smp_t sq[$];
    int   seg_st[$];
    int   seg_len[$];
    logic mon_en = 1'b0;
    logic mon_tk;
    int   n_cmp = 0;
    int   n_err = 0;

    // One output sample per tick edge
    always @(posedge txclk) begin
        mon_tk = itick;
        #1;
        if (mon_en && mon_tk === 1'b1)
            sq.push_back('{d: ogdat, dv: ogdv, er: oger, sent: osent, under: ounder});
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] fbyte(input int f, input int i);
        return 8'((i * 7 + f * 29 + 3) % 256);
    endfunction

    task automatic add_frame(input int f, input int len);
        for (int i = 0; i < len; i++)
            fq.push_back('{d: fbyte(f, i), sop: (i == 0), eop: (i == len - 1)});
    endtask

    // Receiver-side MSB-first CRC over bytes sent LSB first
    function automatic logic [31:0] residue(input int st, input int n);
        logic [31:0] c;
        logic        fbk;
        c = 32'hFFFFFFFF;
        for (int k = 0; k < n; k++) begin
            if (st + k < sq.size()) begin
                for (int b = 0; b < 8; b++) begin
                    fbk = c[31] ^ sq[st + k].d[b];
                    c = {c[30:0], 1'b0} ^ (fbk ? 32'h04C11DB7 : 32'h0);
                end
            end
        end
        return c;
    endfunction

    task automatic find_segs();
        seg_st.delete();
        seg_len.delete();
        for (int i = 0; i < sq.size(); i++) begin
            if (sq[i].dv === 1'b1 && (i == 0 || sq[i-1].dv !== 1'b1)) begin
                int j;
                j = i;
                while (j < sq.size() && sq[j].dv === 1'b1) j++;
                seg_st.push_back(i);
                seg_len.push_back(j - i);
            end
        end
    endtask

    task automatic count_flags(output int ns, output int nu, output int ne);
        ns = 0; nu = 0; ne = 0;
        for (int i = 0; i < sq.size(); i++) begin
            if (sq[i].sent === 1'b1)  ns++;
            if (sq[i].under === 1'b1) nu++;
            if (sq[i].er === 1'b1)    ne++;
        end
    endtask

    task automatic cmp_prefix(input string nm, input int st, input int prm, input int f,
                              input int flen, input int nb);
        int         mism;
        logic [7:0] e;
        mism = 0;
        for (int k = 0; k < nb; k++) begin
            if (k <= prm)                e = 8'h55;
            else if (k == prm + 1)       e = 8'hD5;
            else if (k - prm - 2 < flen) e = fbyte(f, k - prm - 2);
            else                         e = 8'h00;
            if (st + k >= sq.size() || sq[st + k].d !== e) mism++;
        end
        check(nm, mism, 0);
    endtask

    task automatic chk_full(input string nm, input int s, input int prm, input int f,
                            input int flen, input int exp_len);
        if (s >= seg_st.size()) begin
            check({nm, "_nseg"}, seg_st.size(), s + 1);
            return;
        end
        check({nm, "_len"}, seg_len[s], exp_len);
        cmp_prefix({nm, "_bytes"}, seg_st[s], prm, f, flen, exp_len - 4);
        check({nm, "_residue"}, residue(seg_st[s] + prm + 2, exp_len - prm - 2), 32'hC704DD7B);
    endtask

    // Drive the byte queue as a FIFO; optional underrun and reset injection
    task automatic run(input int tper, input int und_at, input int rst_at, input int ncyc,
                       output int consumed, output int offv);
        int idx;
        bit und_done, rst_done, rchk, xfer;
        idx = 0; und_done = 0; rst_done = 0; rchk = 0; offv = 0;
        sq.delete();
        mon_en = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge txclk);
            rst_  = 1'b1;
            itick = ((c % tper) == 0);
            if (idx < fq.size()) begin
                ival = 1'b1;
                idat = fq[idx].d;
                isop = fq[idx].sop;
                ieop = fq[idx].eop;
                if (idx == und_at && !und_done && itick) begin
                    ival = 1'b0;
                    und_done = 1;
                end
                if (idx == rst_at && !rst_done) begin
                    rst_ = 1'b0;
                    rst_done = 1;
                    rchk = 1;
                end
            end else begin
                ival = 1'b0; idat = 8'h00; isop = 1'b0; ieop = 1'b0;
            end
            #1;
            if (ordy && !itick) offv++;
            xfer = ival && ordy;
            @(posedge txclk);
            #2;
            if (xfer) idx++;
            if (rchk) begin
                check("rst_outs", 32'({ogdat, ogdv, oger, osent, ounder}), 32'h0);
                rchk = 0;
            end
        end
        mon_en = 1'b0;
        consumed = idx;
    endtask

    vec_t vt[7];

    initial begin
        int cons, offv, ns, nu, ne;

        rst_ = 1'b0; itick = 1'b1; ival = 1'b1; isop = 1'b0; ieop = 1'b0; idat = 8'hAA;
        up_txen = 1'b1; up_txnumprm = 4'd6; up_txpad = 1'b0; up_txipg = 4'd12;
        repeat (3) @(posedge txclk);
        #2;
        check("reset_outs", 32'({ogdat, ogdv, oger, osent, ounder}), 32'h0);
        check("reset_ordy", 32'(ordy), 32'h0);
        @(negedge txclk);
        rst_ = 1'b1; ival = 1'b0;
        repeat (3) @(posedge txclk);

        //        len pad tper und prm ipg seg0 seg1 gap sent under
        vt[0] = '{60, 0, 1,  -1, 6, 12, 72, 72, 13, 2, 0};
        vt[1] = '{20, 1, 1,  -1, 6, 12, 72, 72, 13, 2, 0};
        vt[2] = '{20, 0, 1,  -1, 6, 12, 32, 32, 13, 2, 0};
        vt[3] = '{60, 0, 10, -1, 6, 12, 72, 72, 13, 2, 0};
        vt[4] = '{60, 0, 1,  30, 6, 12, 39, 72, 43, 1, 1};
        vt[5] = '{64, 1, 1,  -1, 2, 0,  72, 72, 2,  2, 0};
        vt[6] = '{59, 1, 1,  -1, 6, 3,  72, 72, 4,  2, 0};

        for (int v = 0; v < 7; v++) begin
            up_txnumprm = 4'(vt[v].prm);
            up_txipg    = 4'(vt[v].ipg);
            up_txpad    = (vt[v].pad != 0);
            fq.delete();
            add_frame(0, vt[v].len);
            add_frame(1, vt[v].len);
            run(vt[v].tper, vt[v].und, -1, 300 * vt[v].tper, cons, offv);
            find_segs();
            check($sformatf("v%0d_consumed", v), cons, fq.size());
            check($sformatf("v%0d_nseg", v), seg_st.size(), 2);
            if (vt[v].und < 0) begin
                chk_full($sformatf("v%0d_f0", v), 0, vt[v].prm, 0, vt[v].len, vt[v].seg0);
            end else if (seg_st.size() > 0) begin
                check($sformatf("v%0d_f0_len", v), seg_len[0], vt[v].seg0);
                cmp_prefix($sformatf("v%0d_f0_bytes", v), seg_st[0], vt[v].prm, 0, vt[v].len,
                           vt[v].prm + 2 + vt[v].und);
                check($sformatf("v%0d_f0_er_last", v),
                      32'(sq[seg_st[0] + seg_len[0] - 1].er), 32'h1);
            end
            chk_full($sformatf("v%0d_f1", v), 1, vt[v].prm, 1, vt[v].len, vt[v].seg1);
            if (seg_st.size() >= 2)
                check($sformatf("v%0d_gap", v), seg_st[1] - (seg_st[0] + seg_len[0]), vt[v].gap);
            count_flags(ns, nu, ne);
            check($sformatf("v%0d_sent", v), ns, vt[v].sent);
            check($sformatf("v%0d_under", v), nu, vt[v].under);
            check($sformatf("v%0d_er", v), ne, vt[v].under);
            check($sformatf("v%0d_ordy_offtick", v), offv, 0);
        end

        // Transmit disabled holds the sop byte; enabling then sends it
        up_txnumprm = 4'd6; up_txipg = 4'd12; up_txpad = 1'b0; up_txen = 1'b0;
        fq.delete();
        add_frame(2, 60);
        run(1, -1, -1, 60, cons, offv);
        find_segs();
        check("txen_off_consumed", cons, 0);
        check("txen_off_nseg", seg_st.size(), 0);
        up_txen = 1'b1;
        run(1, -1, -1, 200, cons, offv);
        find_segs();
        check("txen_on_nseg", seg_st.size(), 1);
        chk_full("txen_on", 0, 6, 2, 60, 72);

        // Stray non-sop bytes in IDLE are consumed silently
        fq.delete();
        fq.push_back('{d: 8'hAA, sop: 1'b0, eop: 1'b0});
        fq.push_back('{d: 8'hBB, sop: 1'b0, eop: 1'b0});
        add_frame(3, 60);
        run(1, -1, -1, 200, cons, offv);
        find_segs();
        count_flags(ns, nu, ne);
        check("drop_consumed", cons, fq.size());
        check("drop_nseg", seg_st.size(), 1);
        chk_full("drop_frame", 0, 6, 3, 60, 72);
        check("drop_sent", ns, 1);

        // Reset while payload byte 10 is pending, then a fresh frame
        fq.delete();
        add_frame(0, 60);
        add_frame(1, 60);
        run(1, -1, 10, 300, cons, offv);
        find_segs();
        count_flags(ns, nu, ne);
        check("rst_consumed", cons, fq.size());
        check("rst_nseg", seg_st.size(), 2);
        if (seg_st.size() > 0) begin
            check("rst_f0_len", seg_len[0], 18);
            cmp_prefix("rst_f0_bytes", seg_st[0], 6, 0, 60, 18);
        end
        chk_full("rst_f1", 1, 6, 1, 60, 72);
        check("rst_sent", ns, 1);
        check("rst_er", ne, 0);
        check("rst_under", nu, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
